// File: rtl/count_ctrl_pkg.sv
// Shared types for the count_ctrl step-counter controller: command opcodes and FSM states.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_RUN  = 2'b10,
        OP_STOP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/count_ctrl_if.sv
// Command handshake plus counter-side strobes and status of count_ctrl.
interface count_ctrl_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_data;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   count_in;
    logic               ld;
    logic [WIDTH-1:0]   v;
    logic               en;
    logic               busy;
    logic               done;
    logic               err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, presc, count_in,
        output cmd_ready, ld, v, en, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, presc, count_in,
        input  cmd_ready, ld, v, en, busy, done, err
    );
endinterface

// File: rtl/count_ctrl_tick_gen.sv
// Step-rate prescaler: ticks once every (i_presc+1) running cycles, restarting from zero on i_clr.
module tick_gen #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_run,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);
    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == i_presc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_tick ? '0 : r_cnt + PRESC_W'(1);
        end
    end
endmodule

// File: rtl/count_ctrl.sv
// Controller that preloads and single-steps an external counter up to a target.
// Optional COUNT_CTRL_AUTORELOAD_EN: on completion reload the counter and run again until STOP.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) (
    input logic         clk,
    input logic         rst,
    count_ctrl_if.slave bus
);
    state_e             r_state;
    logic               r_live;
    logic               r_ld;
    logic               r_done;
    logic               r_err;
    logic [WIDTH-1:0]   r_v;
    logic [WIDTH-1:0]   r_target;
    logic [WIDTH-1:0]   r_reload;
    logic [PRESC_W-1:0] r_presc;

    op_e  w_op;
    logic w_accept;
    logic w_stop;
    logic w_match;
    logic w_run;
    logic w_tick;
    logic w_en;
    logic w_presc_clr;

    assign w_op        = op_e'(bus.cmd_op);
    assign w_accept    = bus.cmd_valid && bus.cmd_ready;
    assign w_stop      = w_accept && (w_op == OP_STOP);
    assign w_match     = (bus.count_in == r_target);
    assign w_run       = (r_state == ST_RUN);
    // STOP and target match both suppress the step in the cycle they occur
    assign w_en        = w_run && w_tick && !w_stop && !w_match;
    assign w_presc_clr = ((r_state == ST_IDLE) && w_accept && (w_op == OP_RUN))
                       || (r_state == ST_DONE);

    tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_presc_clr),
        .i_run   (w_run),
        .i_presc (r_presc),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_ld     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_v      <= '0;
            r_target <= '0;
            r_reload <= '0;
            r_presc  <= '0;
        end else begin
            r_live <= 1'b1;
            r_ld   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_LOAD: begin
                                r_v      <= bus.cmd_data;
                                r_reload <= bus.cmd_data;
                                r_ld     <= 1'b1;
                                r_state  <= ST_LOAD;
                            end
                            OP_RUN: begin
                                r_target <= bus.cmd_data;
                                r_presc  <= bus.presc;
                                r_state  <= ST_RUN;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD: r_state <= ST_IDLE;
                ST_RUN: begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // LOAD/RUN while running are rejected without disturbing the run
                        if (w_accept && ((w_op == OP_LOAD) || (w_op == OP_RUN))) begin
                            r_err <= 1'b1;
                        end
                        if (w_match) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_v     <= r_reload;
`ifdef COUNT_CTRL_AUTORELOAD_EN
                            r_ld    <= 1'b1;
`endif
                        end
                    end
                end
                ST_DONE: begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
                    r_state <= ST_RUN;
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = r_live && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.ld        = r_ld;
    assign bus.v         = r_v;
    assign bus.en        = w_en;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_count_ctrl.sv
// Randomized bench for count_ctrl with an attached counter and a transaction-level expectation model.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    count_ctrl_if #(.WIDTH(8), .PRESC_W(4)) bus ();

    count_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // attached counter: ld has priority over en
    logic [7:0] cnt_m = 8'd0;
    always @(posedge clk) begin
        if (bus.ld)      cnt_m <= bus.v;
        else if (bus.en) cnt_m <= cnt_m + 8'd1;
    end
    assign bus.count_in = cnt_m;

    // monitor accumulates event totals sampled mid-cycle
    int en_cyc[$];
    int ld_tot = 0, done_tot = 0, done_ld_tot = 0, err_tot = 0, ovl_tot = 0;
    int last_ld_v = 0, last_done_cyc = 0;
    always @(negedge clk) begin
        if (bus.en) en_cyc.push_back(cyc);
        if (bus.ld) begin ld_tot++; last_ld_v = int'(bus.v); end
        if (bus.done) begin
            done_tot++;
            last_done_cyc = cyc;
            if (bus.ld) done_ld_tot++;
        end
        if (bus.err) err_tot++;
        if (bus.ld && bus.en) ovl_tot++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [3:0] p);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("cmd_ready_wait", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d; bus.presc = p;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && bus.busy; k++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", int'(bus.busy), 0);
    endtask

    // LOAD l, RUN t with prescaler p; optional STOP / illegal command after a given number of steps
    task automatic run_scn(input logic [7:0] l, input logic [7:0] t, input logic [3:0] p,
                           input int stop_after, input int ill_at);
        int l0, e0, d0, r0, c_acc, diff, n, bad, budget;
        logic [7:0] dd;
        bit stopped, ill;
        l0 = ld_tot;
        issue(2'(OP_LOAD), l, 4'd0);
        wait_idle(10);
        chk("ld_pulses", ld_tot - l0, 1);
        chk("ld_v", last_ld_v, int'(l));
        chk("cnt_loaded", int'(cnt_m), int'(l));
        dd = t - l;
        diff = int'(dd);
        e0 = en_cyc.size(); d0 = done_tot; r0 = err_tot;
        stopped = 0; ill = 0;
        issue(2'(OP_RUN), t, p);
        c_acc = cyc;
        budget = (diff + 2) * (int'(p) + 1) + 20;
        for (int k = 0; k < budget && bus.busy; k++) begin
            if (stop_after >= 0 && !stopped && (en_cyc.size() - e0) == stop_after) begin
                bus.cmd_valid = 1'b1; bus.cmd_op = 2'(OP_STOP); stopped = 1;
            end else if (ill_at >= 0 && !ill && (en_cyc.size() - e0) == ill_at) begin
                bus.cmd_valid = 1'b1; bus.cmd_op = ($urandom_range(0, 1) != 0) ? 2'(OP_LOAD) : 2'(OP_RUN);
                bus.cmd_data = 8'($urandom); ill = 1;
            end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
        end
        chk("run_idle", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        n = en_cyc.size() - e0;
        if (stop_after >= 0) begin
            chk("stop_en_cnt", n, stop_after);
            chk("stop_no_done", done_tot - d0, 0);
            chk("stop_cnt", int'(cnt_m), int'(8'(l + 8'(stop_after))));
        end else begin
            chk("en_cnt", n, diff);
            chk("done_cnt", done_tot - d0, 1);
            chk("final_cnt", int'(cnt_m), int'(t));
            if (n > 0) chk("done_cyc", last_done_cyc, en_cyc[$] + 2);
            else       chk("done_cyc0", last_done_cyc, c_acc + 1);
        end
        chk("err_cnt", err_tot - r0, (ill_at >= 0) ? 1 : 0);
        if (n > 0) chk("en_first", en_cyc[e0] - c_acc, int'(p));
        bad = 0;
        for (int i = e0 + 1; i < en_cyc.size(); i++)
            if (en_cyc[i] - en_cyc[i-1] != int'(p) + 1) bad++;
        chk("en_gap", bad, 0);
    endtask

    initial begin
        int d0, r0, e0, l0, diff, sa, ia;
        logic [7:0] l, t;
        logic [3:0] p;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_data = 8'd0; bus.presc = 4'd0;

        // reset state
        #2;
        chk("rst_ld", int'(bus.ld), 0);
        chk("rst_en", int'(bus.en), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.cmd_ready), 0);
        chk("rst_v", int'(bus.v), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", int'(bus.cmd_ready), 1);
        chk("rel_busy", int'(bus.busy), 0);

        // NOP/STOP in IDLE are silently accepted
        r0 = err_tot;
        issue(2'(OP_NOP), 8'h11, 4'd0);
        issue(2'(OP_STOP), 8'h22, 4'd0);
        @(posedge clk); #1;
        chk("idle_nop_err", err_tot - r0, 0);
        chk("idle_nop_busy", int'(bus.busy), 0);

`ifndef COUNT_CTRL_AUTORELOAD_EN
        run_scn(8'h05, 8'h08, 4'd0, -1, -1);
        run_scn(8'h00, 8'h02, 4'd3, -1, -1);
        run_scn(8'hFE, 8'h01, 4'd0, -1, -1);
        run_scn(8'h00, 8'h20, 4'd0, 4, 2);
        run_scn(8'h33, 8'h33, 4'd2, -1, -1);

        for (int it = 0; it < 12; it++) begin
            l = 8'($urandom);
            diff = $urandom_range(0, 40);
            t = l + 8'(diff);
            p = 4'($urandom_range(0, 3));
            sa = -1; ia = -1;
            if (diff > 0 && $urandom_range(0, 2) == 0) sa = $urandom_range(0, diff - 1);
            if (diff > 1 && $urandom_range(0, 2) == 0) ia = $urandom_range(0, diff - 1);
            if (sa >= 0 && ia >= sa) ia = -1;
            run_scn(l, t, p, sa, ia);
        end

        // a single completion only, no reload
        d0 = done_tot; l0 = ld_tot;
        repeat (10) @(posedge clk);
        #1;
        chk("no_autoreload_done", done_tot - d0, 0);
        chk("no_autoreload_ld", ld_tot - l0, 0);
`else
        // periodic completion with reload until STOP
        l0 = ld_tot; d0 = done_tot;
        issue(2'(OP_LOAD), 8'h03, 4'd0);
        wait_idle(10);
        issue(2'(OP_RUN), 8'h05, 4'd0);
        for (int k = 0; k < 100 && (done_tot - d0) < 3; k++) begin
            @(posedge clk); #1;
        end
        issue(2'(OP_STOP), 8'h00, 4'd0);
        wait_idle(10);
        chk("ar_done_cnt", done_tot - d0, 3);
        chk("ar_done_with_ld", done_ld_tot, 3);
        chk("ar_ld_cnt", ld_tot - l0, 4);
        chk("ar_ld_v", last_ld_v, 3);
        chk("ar_cnt", int'(cnt_m), 3);
`endif

        // asynchronous reset in the middle of a run
        issue(2'(OP_LOAD), 8'h10, 4'd0);
        wait_idle(10);
        issue(2'(OP_RUN), 8'h80, 4'd1);
        repeat (10) @(posedge clk);
        #2;
        d0 = done_tot; r0 = err_tot;
        rst = 1'b0;
        #1;
        chk("arst_en", int'(bus.en), 0);
        chk("arst_ld", int'(bus.ld), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_ready", int'(bus.cmd_ready), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_err", int'(bus.err), 0);
        chk("arst_v", int'(bus.v), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_ready", int'(bus.cmd_ready), 1);
        chk("arst_rel_busy", int'(bus.busy), 0);
        chk("arst_no_done", done_tot - d0, 0);
        chk("arst_no_err", err_tot - r0, 0);

        // RUN to the current count finishes without stepping
        e0 = en_cyc.size(); d0 = done_tot;
        issue(2'(OP_RUN), cnt_m, 4'd2);
        wait_idle(10);
`ifndef COUNT_CTRL_AUTORELOAD_EN
        chk("eq_done", done_tot - d0, 1);
`endif
        chk("eq_en", en_cyc.size() - e0, 0);

        chk("ld_en_overlap", ovl_tot, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
